// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Brief    : Instruction fetch stage and IF/ID pipeline register for the
//             16-bit pipelined CPU. Talks to a variable-latency instruction
//             memory, absorbs stalls in a one-entry skid buffer, drops stale
//             responses after a redirect and freezes on HLT.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'hA000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        IF_Flush,
    input  logic [15:0] br_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic [15:0] IF_ID_Inst,
    output logic [15:0] IF_ID_PCp2,
    output logic        IF_ID_valid,
    output logic        halted
);

    // FETCH   : a request at r_pc is on the bus
    // DISCARD : the request on the bus is stale; r_pendPc holds the redirect
    // HOLD    : a response sits in the skid buffer while ID is stalled
    // HALTED  : HLT is resident in IF/ID, no requests issued
    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DISCARD = 2'd1,
        ST_HOLD    = 2'd2,
        ST_HALTED  = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_pendPc;
    logic [15:0] r_bufInst;
    logic [15:0] r_bufPc;
    logic [15:0] r_ifInst;
    logic [15:0] r_ifPcp2;
    logic        r_ifValid;

    state_t      w_stateNext;
    logic [15:0] w_pcNext;
    logic [15:0] w_pendPcNext;
    logic [15:0] w_bufInstNext;
    logic [15:0] w_bufPcNext;
    logic [15:0] w_ifInstNext;
    logic [15:0] w_ifPcp2Next;
    logic        w_ifValidNext;

    logic [15:0] w_pcPlus2;
    logic        w_outstanding;

    assign w_pcPlus2     = r_pc + 16'd2;
    assign w_outstanding = (r_state == ST_FETCH) || (r_state == ST_DISCARD);

    // Next-state and next-register computation; priority is flush > stall > normal
    always_comb begin
        w_stateNext   = r_state;
        w_pcNext      = r_pc;
        w_pendPcNext  = r_pendPc;
        w_bufInstNext = r_bufInst;
        w_bufPcNext   = r_bufPc;
        w_ifInstNext  = r_ifInst;
        w_ifPcp2Next  = r_ifPcp2;
        w_ifValidNext = r_ifValid;

        if (IF_Flush) begin
            w_ifInstNext  = NOP_INST;
            w_ifValidNext = 1'b0;
            w_bufInstNext = NOP_INST;
            w_bufPcNext   = 16'h0000;
            if (w_outstanding && !imem_rdy) begin
                // The memory still owes us a response: let it finish, then redirect
                w_pendPcNext = br_target;
                w_stateNext  = ST_DISCARD;
            end else begin
                w_pcNext    = br_target;
                w_stateNext = ST_FETCH;
            end
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_rdy) begin
                        w_pcNext = w_pcPlus2;
                        if (stall) begin
                            w_bufInstNext = imem_data;
                            w_bufPcNext   = r_pc;
                            w_stateNext   = ST_HOLD;
                        end else begin
                            w_ifInstNext  = imem_data;
                            w_ifPcp2Next  = w_pcPlus2;
                            w_ifValidNext = 1'b1;
                            w_stateNext   = (imem_data[15:12] == 4'hF) ? ST_HALTED : ST_FETCH;
                        end
                    end else if (!stall) begin
                        w_ifInstNext  = NOP_INST;
                        w_ifValidNext = 1'b0;
                    end
                end
                ST_DISCARD: begin
                    if (imem_rdy) begin
                        w_pcNext    = r_pendPc;
                        w_stateNext = ST_FETCH;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        w_ifInstNext  = r_bufInst;
                        w_ifPcp2Next  = r_bufPc + 16'd2;
                        w_ifValidNext = 1'b1;
                        w_bufInstNext = NOP_INST;
                        w_bufPcNext   = 16'h0000;
                        w_stateNext   = (r_bufInst[15:12] == 4'hF) ? ST_HALTED : ST_FETCH;
                    end
                end
                default: begin
                    // HALTED: everything holds until a flush or reset
                end
            endcase
        end
    end

    // State, PC, skid buffer and IF/ID registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_pc      <= RESET_PC;
            r_pendPc  <= 16'h0000;
            r_bufInst <= NOP_INST;
            r_bufPc   <= 16'h0000;
            r_ifInst  <= NOP_INST;
            r_ifPcp2  <= 16'h0000;
            r_ifValid <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_pc      <= w_pcNext;
            r_pendPc  <= w_pendPcNext;
            r_bufInst <= w_bufInstNext;
            r_bufPc   <= w_bufPcNext;
            r_ifInst  <= w_ifInstNext;
            r_ifPcp2  <= w_ifPcp2Next;
            r_ifValid <= w_ifValidNext;
        end
    end

    // A stale request in DISCARD keeps its original address until it completes
    assign imem_req    = !rst && w_outstanding;
    assign imem_addr   = r_pc;
    assign IF_ID_Inst  = r_ifInst;
    assign IF_ID_PCp2  = r_ifPcp2;
    assign IF_ID_valid = r_ifValid;
    assign halted      = (r_state == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Brief    : Scoreboard bench for fetch_stage. A variable-latency memory
//             model answers requests; the expected program-order instruction
//             stream is queued whenever reset or a redirect is issued, and a
//             monitor pops it on every real instruction entering IF/ID.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] NOP_INST = 16'hA000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        IF_Flush;
    logic [15:0] br_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic [15:0] IF_ID_Inst;
    logic [15:0] IF_ID_PCp2;
    logic        IF_ID_valid;
    logic        halted;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .IF_Flush   (IF_Flush),
        .br_target  (br_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdy   (imem_rdy),
        .imem_data  (imem_data),
        .IF_ID_Inst (IF_ID_Inst),
        .IF_ID_PCp2 (IF_ID_PCp2),
        .IF_ID_valid(IF_ID_valid),
        .halted     (halted)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction memory model ----------------
    logic [15:0] mem [0:32767];
    int          waitMin = 0;
    int          waitMax = 0;
    bit          memActive = 1'b0;
    int          memCnt = 0;
    logic [15:0] memAddr = 16'h0000;

    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            memActive = 1'b0;
            imem_rdy  = 1'b0;
        end else if (imem_req) begin
            if (!memActive) begin
                memActive = 1'b1;
                memAddr   = imem_addr;
                memCnt    = int'($urandom_range(waitMax, waitMin));
            end else begin
                chk("addr_stable", {16'h0, imem_addr}, {16'h0, memAddr});
            end
            if (memCnt == 0) begin
                imem_rdy  = 1'b1;
                imem_data = mem[imem_addr[15:1]];
                memActive = 1'b0;
            end else begin
                imem_rdy  = 1'b0;
                imem_data = 16'($urandom);
                memCnt--;
            end
        end else begin
            imem_rdy  = 1'b0;
            imem_data = 16'($urandom);
        end
    end

    // ---------------- reference model: program-order stream ----------------
    typedef struct {
        logic [15:0] inst;
        logic [15:0] pcp2;
    } exp_t;

    exp_t        expQ[$];
    logic [15:0] modelPc   = 16'h0000;
    bit          modelStop = 1'b0;

    function automatic void topUp();
        exp_t e;
        while (expQ.size() < 8 && !modelStop) begin
            e.inst = mem[modelPc[15:1]];
            e.pcp2 = modelPc + 16'd2;
            expQ.push_back(e);
            if (e.inst[15:12] == 4'hF) modelStop = 1'b1;
            modelPc = modelPc + 16'd2;
        end
    endfunction

    function automatic void redirect(input logic [15:0] t);
        expQ.delete();
        modelPc   = t;
        modelStop = 1'b0;
        topUp();
    endfunction

    // One cycle of stimulus, applied just after the falling edge
    task automatic cyc(input bit r, input bit s, input bit f, input logic [15:0] t);
        @(negedge clk);
        rst       = r;
        stall     = s;
        IF_Flush  = f;
        br_target = t;
        if (r)      redirect(RESET_PC);
        else if (f) redirect(t);
        else        topUp();
    endtask

    // ---------------- monitor ----------------
    int          delivered = 0;
    logic        sR, sS, sF;
    logic [15:0] pInst  = 16'h0;
    logic [15:0] pPcp2  = 16'h0;
    logic        pValid = 1'b0;
    logic        pHalted = 1'b0;

    always begin
        exp_t e;
        @(posedge clk);
        sR = rst;
        sS = stall;
        sF = IF_Flush;
        #1;
        if (sR) begin
            chk("rst_inst",  {16'h0, IF_ID_Inst}, {16'h0, NOP_INST});
            chk("rst_pcp2",  {16'h0, IF_ID_PCp2}, 32'h0);
            chk("rst_valid", {31'h0, IF_ID_valid}, 32'h0);
            chk("rst_halted", {31'h0, halted}, 32'h0);
            chk("rst_req",   {31'h0, imem_req}, 32'h0);
        end else if (sF) begin
            chk("flush_inst",   {16'h0, IF_ID_Inst}, {16'h0, NOP_INST});
            chk("flush_valid",  {31'h0, IF_ID_valid}, 32'h0);
            chk("flush_halted", {31'h0, halted}, 32'h0);
        end else if (sS || pHalted) begin
            chk("hold_inst",   {16'h0, IF_ID_Inst}, {16'h0, pInst});
            chk("hold_pcp2",   {16'h0, IF_ID_PCp2}, {16'h0, pPcp2});
            chk("hold_valid",  {31'h0, IF_ID_valid}, {31'h0, pValid});
            chk("hold_halted", {31'h0, halted}, {31'h0, pHalted});
        end else if (IF_ID_valid) begin
            delivered++;
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL extra_delivery actual=%h expected=none t=%0t", IF_ID_Inst, $time);
            end else begin
                e = expQ.pop_front();
                chk("deliv_inst",   {16'h0, IF_ID_Inst}, {16'h0, e.inst});
                chk("deliv_pcp2",   {16'h0, IF_ID_PCp2}, {16'h0, e.pcp2});
                chk("deliv_halted", {31'h0, halted}, {31'h0, (e.inst[15:12] == 4'hF)});
            end
        end else begin
            chk("bubble_inst",   {16'h0, IF_ID_Inst}, {16'h0, NOP_INST});
            chk("bubble_halted", {31'h0, halted}, 32'h0);
        end
        if (halted) chk("halted_req", {31'h0, imem_req}, 32'h0);
        pInst   = IF_ID_Inst;
        pPcp2   = IF_ID_PCp2;
        pValid  = IF_ID_valid;
        pHalted = halted;
    end

    // ---------------- directed and random stimulus ----------------
    initial begin
        int  d0;
        bit  ok;
        logic [15:0] w;
        rst = 1'b1; stall = 1'b0; IF_Flush = 1'b0; br_target = 16'h0;
        imem_rdy = 1'b0; imem_data = 16'h0;
        for (int i = 0; i < 32768; i++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hF) w[15:12] = 4'hE;
            mem[i] = w;
        end
        mem[16'h0104 >> 1] = 16'hF000;
        redirect(RESET_PC);

        // Zero-wait streaming from reset: one instruction per cycle
        waitMin = 0; waitMax = 0;
        cyc(1, 0, 0, 16'h0); cyc(1, 0, 0, 16'h0);
        d0 = delivered;
        repeat (21) cyc(0, 0, 0, 16'h0);
        chk("zero_wait_throughput", delivered - d0, 20);

        // Two wait states: one instruction every three cycles
        waitMin = 2; waitMax = 2;
        ok = 1'b0; d0 = delivered;
        for (int i = 0; i < 12 && !ok; i++) begin
            cyc(0, 0, 0, 16'h0);
            if (delivered != d0) ok = 1'b1;
        end
        chk("timeout_wait2", {31'h0, ok}, 32'h1);
        d0 = delivered;
        repeat (9) cyc(0, 0, 0, 16'h0);
        chk("wait2_throughput", delivered - d0, 3);

        // Stall over a returning response: skid buffer, no request in HOLD
        waitMin = 0; waitMax = 0;
        cyc(0, 0, 1, 16'h0020);
        repeat (4) cyc(0, 0, 0, 16'h0);
        cyc(0, 1, 0, 16'h0);
        cyc(0, 1, 0, 16'h0);
        chk("hold_no_req_a", {31'h0, imem_req}, 32'h0);
        cyc(0, 1, 0, 16'h0);
        chk("hold_no_req_b", {31'h0, imem_req}, 32'h0);
        repeat (6) cyc(0, 0, 0, 16'h0);

        // Redirect while a 3-wait request at 0x0008 is outstanding
        waitMin = 3; waitMax = 3;
        cyc(0, 0, 1, 16'h0000);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            cyc(0, 0, 0, 16'h0);
            if (imem_req && imem_addr == 16'h0008) ok = 1'b1;
        end
        chk("timeout_reach_0008", {31'h0, ok}, 32'h1);
        cyc(0, 0, 1, 16'h0040);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            cyc(0, 0, 0, 16'h0);
            if (imem_addr != 16'h0008) ok = 1'b1;
        end
        chk("discard_next_addr", {16'h0, imem_addr}, 32'h0040);
        repeat (10) cyc(0, 0, 0, 16'h0);

        // HLT freezes fetch; a redirect releases it with two-cycle latency
        waitMin = 0; waitMax = 0;
        cyc(0, 0, 1, 16'h0100);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            cyc(0, 0, 0, 16'h0);
            if (halted) ok = 1'b1;
        end
        chk("timeout_halt", {31'h0, ok}, 32'h1);
        repeat (10) cyc(0, 0, 0, 16'h0);
        chk("halt_req_off", {31'h0, imem_req}, 32'h0);
        cyc(0, 0, 1, 16'h0010);
        cyc(0, 0, 0, 16'h0);
        chk("unhalt", {31'h0, halted}, 32'h0);
        chk("redirect_addr", {16'h0, imem_addr}, 32'h0010);
        cyc(0, 0, 0, 16'h0);
        chk("redirect_latency_inst", {16'h0, IF_ID_Inst}, {16'h0, mem[16'h0010 >> 1]});
        chk("redirect_latency_pcp2", {16'h0, IF_ID_PCp2}, 32'h0012);
        repeat (4) cyc(0, 0, 0, 16'h0);

        // Flush together with stall, then stream through the 0xFFFE wrap
        cyc(0, 1, 1, 16'hFFFC);
        repeat (8) cyc(0, 0, 0, 16'h0);

        // Reset in the middle of a DISCARD
        waitMin = 3; waitMax = 3;
        cyc(0, 0, 1, 16'h0200);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            cyc(0, 0, 0, 16'h0);
            if (imem_req && imem_addr == 16'h0200) ok = 1'b1;
        end
        chk("timeout_reach_0200", {31'h0, ok}, 32'h1);
        cyc(0, 0, 1, 16'h0300);
        cyc(0, 0, 0, 16'h0);
        chk("discard_addr_held", {16'h0, imem_addr}, 32'h0200);
        cyc(1, 0, 0, 16'h0);
        cyc(1, 0, 0, 16'h0);
        repeat (12) cyc(0, 0, 0, 16'h0);

        // Randomized traffic
        waitMin = 0; waitMax = 3;
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 29) == 0),
                16'($urandom) & 16'hFFFE);
        end
        repeat (3) cyc(0, 0, 0, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
